pipeline_hazard_ctrl: RTL and testbench
=======================================

Name: pipeline_hazard_ctrl

Overview:
Central hazard and stall controller for the 3-stage pipeline (IF | DE/EX | MEM/WB).
- Generates operand-forwarding selects for the DE/EX stage.
- Freezes the pipeline while a data-memory access waits on mem_ready, with a timeout and error pulse.
- Flushes the IF/DE buffer on a taken branch.
- Drives the enable/flush controls of the PC, the IF/DE buffer and the DE/EX→MEM/WB control/data buffers.

Parameters:
- REG_AW, 5, register-index width.
- MEM_TIMEOUT, 15, maximum wait cycles on mem_ready before abort (≥1).
- CNT_W, 32, width of the performance counters.

Ports:
- clk  in  1  clock
- rst  in  1  reset
- rs1_de  in  REG_AW  source register 1 of the instruction in DE/EX
- rs2_de  in  REG_AW  source register 2 of the instruction in DE/EX
- rd_mw  in  REG_AW  destination register of the instruction in MEM/WB
- rf_en_mw  in  1  register-file write enable, MEM/WB
- wb_sel_mw  in  2  write-back select, MEM/WB
- rd_en_mw  in  1  data-memory read, MEM/WB
- wr_en_mw  in  1  data-memory write, MEM/WB
- mem_ready  in  1  data memory completes the access this cycle
- br_taken  in  1  branch resolved taken in DE/EX
- fwd_a  out  2  operand-A forward select
- fwd_b  out  2  operand-B forward select
- stall_pc  out  1  hold PC
- stall_b1  out  1  hold IF/DE buffer
- stall_b2  out  1  hold MEM/WB buffers
- flush_b1  out  1  clear IF/DE buffer to NOP
- bubble_b2  out  1  load zero control into MEM/WB buffers
- mem_err  out  1  one-cycle pulse on access timeout
- stall_cnt  out  CNT_W  stall-cycle count
- flush_cnt  out  CNT_W  flush count

Behaviour:
- Reset is asynchronous, active-high, on rst; clock is clk. On reset: state=RUN, wait counter=0, mem_err=0, counters=0. All combinational outputs are then 0 whenever the inputs are idle.
- wb_sel encoding: 00 ALU, 01 MEM, 10 PC+4.
- fwd_x encoding: 00 register file, 01 ALU result (MW), 10 load data, 11 PC+4 (MW).
- fwd_a is combinational:
  - If rf_en_mw && rd_mw!=0 && rd_mw==rs1_de: fwd_a = {ALU→01, MEM→10, PC+4→11} by wb_sel_mw. wb_sel_mw=11 is treated as 00.
  - Otherwise fwd_a=00.
  - fwd_b is identical, using rs2_de.
- mem_acc = rd_en_mw | wr_en_mw.
- FSM states: RUN, MEM_WAIT.
  - RUN: if mem_acc && !mem_ready, then stall_pc=stall_b1=stall_b2=1 and go to MEM_WAIT with cnt=1. If mem_ready is high with mem_acc, stay in RUN with no stall (zero-wait access).
  - MEM_WAIT: stalls stay asserted (combinational, same cycle).
    - mem_ready=1: stalls drop in the same cycle, go to RUN.
    - Else if cnt==MEM_TIMEOUT: mem_err=1 for one cycle, stalls drop, bubble_b2=1, go to RUN. The instruction is abandoned and its write-back is suppressed.
    - Else cnt++.
  - The wait counter is $clog2(MEM_TIMEOUT+1) bits wide and cleared on every entry to RUN.
- Branch handling:
  - flush_b1 = br_taken && !stall_b1.
  - While the pipeline is stalled, the branch is held: DE/EX is frozen, so br_taken stays high, and flush_b1 asserts in the release cycle.
  - flush_b1 never asserts together with stall_b1.
- Simultaneous timeout and br_taken: bubble_b2 and flush_b1 both assert in the same cycle.
- Reset mid-wait: returns immediately to RUN; the pending access is dropped and mem_err is not pulsed.
- Forwarding outputs remain valid during a stall; they track the frozen inputs.

Optional Feature:
HAZARD_PERF_CNT_EN.
- Defined:
  - stall_cnt increments on every cycle with stall_pc=1.
  - flush_cnt increments on every cycle with flush_b1=1 or bubble_b2=1.
  - Both counters saturate at all-ones and clear on reset.
- Undefined: both ports are still present and tied to 0. No counter flops are synthesised.

Decomposition:
- Package pipeline_pkg holds:
  - wb_sel_e (ALU/MEM/PC4)
  - fwd_sel_e (RF/ALU/LOAD/PC4)
  - hz_state_e (RUN/MEM_WAIT)
  - default REG_AW.
- One natural sub-module: hazard_fwd_unit, the purely combinational rs/rd compare producing fwd_a/fwd_b.
- The FSM, the wait counter and the performance counters stay in the top module.

Test Plan:
- rd_mw=5, rf_en_mw=1, wb_sel_mw=00, rs1_de=5, rs2_de=5 -> fwd_a=01, fwd_b=01. Repeat with rd_mw=0 -> both 00.
- wb_sel_mw=01, rd_mw=7, rs2_de=7, rs1_de=3 -> fwd_b=10, fwd_a=00.
- rd_en_mw=1 with mem_ready low for 3 cycles then high -> stall_pc/b1/b2 high for exactly 3 cycles, low in the ready cycle. With the feature on, stall_cnt=3.
- wr_en_mw=1, mem_ready held low, MEM_TIMEOUT=15 -> stalls for 16 cycles, then mem_err=1 and bubble_b2=1 for one cycle, state back to RUN.
- br_taken=1 with no memory access -> flush_b1=1 in the same cycle, no stalls. br_taken=1 during a 2-cycle wait -> flush_b1=0 while stalled, 1 in the release cycle.
- Assert rst during MEM_WAIT (cycle 4) -> all stalls 0 immediately, mem_err never pulses, counters=0.

Source files
------------

// File: rtl/pipeline_hazard_ctrl_pkg.sv
// Shared types for the 3-stage pipeline hazard controller: write-back and
// forward-select encodings, controller state and the default register-index width.
package pipeline_pkg;

    localparam int REG_AW_DEF = 5;

    typedef enum logic [1:0] {
        WB_ALU = 2'b00,
        WB_MEM = 2'b01,
        WB_PC4 = 2'b10
    } wb_sel_e;

    typedef enum logic [1:0] {
        FWD_RF   = 2'b00,
        FWD_ALU  = 2'b01,
        FWD_LOAD = 2'b10,
        FWD_PC4  = 2'b11
    } fwd_sel_e;

    typedef enum logic {
        RUN      = 1'b0,
        MEM_WAIT = 1'b1
    } hz_state_e;

endpackage

// File: rtl/pipeline_hazard_ctrl_fwd.sv
// Operand-forwarding compare: matches the DE/EX sources against the MEM/WB
// destination and picks the forwarded value by the MEM/WB write-back select.
module hazard_fwd_unit
    import pipeline_pkg::*;
#(
    parameter int REG_AW = REG_AW_DEF
) (
    input  logic [REG_AW-1:0] rs1_i,
    input  logic [REG_AW-1:0] rs2_i,
    input  logic [REG_AW-1:0] rd_i,
    input  logic              rf_en_i,
    input  logic [1:0]        wb_sel_i,
    output fwd_sel_e          fwd_a_o,
    output fwd_sel_e          fwd_b_o
);

    fwd_sel_e wb_src;
    logic     rd_live;

    // x0 is never a real producer; unused wb_sel code 11 behaves as ALU
    always_comb begin
        wb_src = FWD_ALU;
        case (wb_sel_e'(wb_sel_i))
            WB_MEM:  wb_src = FWD_LOAD;
            WB_PC4:  wb_src = FWD_PC4;
            default: wb_src = FWD_ALU;
        endcase
        rd_live = rf_en_i && (rd_i != '0);
        fwd_a_o = (rd_live && rd_i == rs1_i) ? wb_src : FWD_RF;
        fwd_b_o = (rd_live && rd_i == rs2_i) ? wb_src : FWD_RF;
    end

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Hazard/stall controller for the IF | DE/EX | MEM/WB pipeline: forwarding
// selects, data-memory wait freeze with timeout abort, branch flush.
// Optional performance counters are built when HAZARD_PERF_CNT_EN is defined;
// otherwise stall_cnt/flush_cnt read as zero.
module pipeline_hazard_ctrl
    import pipeline_pkg::*;
#(
    parameter int REG_AW      = REG_AW_DEF,
    parameter int MEM_TIMEOUT = 15,
    parameter int CNT_W       = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [REG_AW-1:0] rs1_de,
    input  logic [REG_AW-1:0] rs2_de,
    input  logic [REG_AW-1:0] rd_mw,
    input  logic              rf_en_mw,
    input  logic [1:0]        wb_sel_mw,
    input  logic              rd_en_mw,
    input  logic              wr_en_mw,
    input  logic              mem_ready,
    input  logic              br_taken,
    output logic [1:0]        fwd_a,
    output logic [1:0]        fwd_b,
    output logic              stall_pc,
    output logic              stall_b1,
    output logic              stall_b2,
    output logic              flush_b1,
    output logic              bubble_b2,
    output logic              mem_err,
    output logic [CNT_W-1:0]  stall_cnt,
    output logic [CNT_W-1:0]  flush_cnt
);

    localparam int                WCNT_W      = $clog2(MEM_TIMEOUT + 1);
    localparam logic [WCNT_W-1:0] TIMEOUT_CNT = WCNT_W'(MEM_TIMEOUT);

    hz_state_e         state_q;
    logic [WCNT_W-1:0] cnt_q;
    logic              err_q;
    logic              mem_acc;
    logic              stall;
    fwd_sel_e          fwd_a_sel, fwd_b_sel;

    hazard_fwd_unit #(.REG_AW(REG_AW)) u_fwd (
        .rs1_i   (rs1_de),
        .rs2_i   (rs2_de),
        .rd_i    (rd_mw),
        .rf_en_i (rf_en_mw),
        .wb_sel_i(wb_sel_mw),
        .fwd_a_o (fwd_a_sel),
        .fwd_b_o (fwd_b_sel)
    );

    assign fwd_a   = fwd_a_sel;
    assign fwd_b   = fwd_b_sel;
    assign mem_acc = rd_en_mw | wr_en_mw;

    // Freeze while the access is outstanding. In the abort cycle (err_q) the
    // MEM/WB buffer still holds the abandoned access, so it must not re-stall.
    always_comb begin
        stall = 1'b0;
        if (!rst) begin
            if (state_q == RUN) stall = mem_acc && !mem_ready && !err_q;
            else                stall = !mem_ready;
        end
    end

    assign stall_pc  = stall;
    assign stall_b1  = stall;
    assign stall_b2  = stall;
    // A held branch flushes only once the freeze releases
    assign flush_b1  = br_taken && !stall;
    // Abort cycle: error pulse and squash of the abandoned write-back coincide
    assign bubble_b2 = err_q;
    assign mem_err   = err_q;

    // Wait FSM: the last wait cycle (cnt==MEM_TIMEOUT) still stalls, the
    // following cycle pulses the error, bubbles MEM/WB and runs again.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= RUN;
            cnt_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            err_q <= 1'b0;
            case (state_q)
                RUN: begin
                    cnt_q <= '0;
                    if (stall) begin
                        state_q <= MEM_WAIT;
                        cnt_q   <= WCNT_W'(1);
                    end
                end
                MEM_WAIT: begin
                    if (mem_ready) begin
                        state_q <= RUN;
                        cnt_q   <= '0;
                    end else if (cnt_q == TIMEOUT_CNT) begin
                        state_q <= RUN;
                        cnt_q   <= '0;
                        err_q   <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q + WCNT_W'(1);
                    end
                end
                default: begin
                    state_q <= RUN;
                    cnt_q   <= '0;
                end
            endcase
        end
    end

`ifdef HAZARD_PERF_CNT_EN
    logic [CNT_W-1:0] stall_cnt_q, flush_cnt_q;

    // Saturating stall-cycle and flush/bubble-cycle counters
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            if (stall && !(&stall_cnt_q))
                stall_cnt_q <= stall_cnt_q + CNT_W'(1);
            if ((flush_b1 || bubble_b2) && !(&flush_cnt_q))
                flush_cnt_q <= flush_cnt_q + CNT_W'(1);
        end
    end

    assign stall_cnt = stall_cnt_q;
    assign flush_cnt = flush_cnt_q;
`else
    assign stall_cnt = '0;
    assign flush_cnt = '0;
`endif

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Self-checking bench for pipeline_hazard_ctrl. Expected output vectors are
// queued as stimulus is applied and popped at the falling edge for comparison.
// Vector layout: {fwd_a[1:0], fwd_b[1:0], stall_pc, stall_b1, stall_b2,
// flush_b1, bubble_b2, mem_err}.
module tb_pipeline_hazard_ctrl;

    localparam int REG_AW      = 5;
    localparam int MEM_TIMEOUT = 15;
    localparam int CNT_W       = 32;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic [REG_AW-1:0] rs1_de = '0, rs2_de = '0, rd_mw = '0;
    logic              rf_en_mw = 1'b0;
    logic [1:0]        wb_sel_mw = 2'b00;
    logic              rd_en_mw = 1'b0, wr_en_mw = 1'b0, mem_ready = 1'b0, br_taken = 1'b0;
    logic [1:0]        fwd_a, fwd_b;
    logic              stall_pc, stall_b1, stall_b2, flush_b1, bubble_b2, mem_err;
    logic [CNT_W-1:0]  stall_cnt, flush_cnt;

    logic [9:0] exp_q[$];
    int         n_chk = 0;
    int         n_pass = 0;
    int         exp_stall = 0;
    int         exp_flush = 0;

    pipeline_hazard_ctrl #(.REG_AW(REG_AW), .MEM_TIMEOUT(MEM_TIMEOUT), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst),
        .rs1_de(rs1_de), .rs2_de(rs2_de), .rd_mw(rd_mw), .rf_en_mw(rf_en_mw),
        .wb_sel_mw(wb_sel_mw), .rd_en_mw(rd_en_mw), .wr_en_mw(wr_en_mw),
        .mem_ready(mem_ready), .br_taken(br_taken),
        .fwd_a(fwd_a), .fwd_b(fwd_b), .stall_pc(stall_pc), .stall_b1(stall_b1),
        .stall_b2(stall_b2), .flush_b1(flush_b1), .bubble_b2(bubble_b2),
        .mem_err(mem_err), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [9:0] mk(input logic [1:0] fa, input logic [1:0] fb,
                                      input logic st, input logic fl,
                                      input logic bub, input logic err);
        return {fa, fb, st, st, st, fl, bub, err};
    endfunction

    // Apply one cycle of inputs just after the rising edge
    task automatic drive(input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rd,
                         input logic rfen, input logic [1:0] wb, input logic rde,
                         input logic wre, input logic rdy, input logic br);
        @(posedge clk);
        #1;
        rs1_de = rs1; rs2_de = rs2; rd_mw = rd; rf_en_mw = rfen; wb_sel_mw = wb;
        rd_en_mw = rde; wr_en_mw = wre; mem_ready = rdy; br_taken = br;
    endtask

    // Queue an expected vector and track what the counters should read
    task automatic push_exp(input logic [9:0] e);
        exp_q.push_back(e);
        if (e[5]) exp_stall++;
        if (e[2] || e[1]) exp_flush++;
    endtask

    function automatic logic [9:0] obs_vec();
        return {fwd_a, fwd_b, stall_pc, stall_b1, stall_b2, flush_b1, bubble_b2, mem_err};
    endfunction

    task automatic test_reset();
        logic [9:0] e;
        repeat (2) @(posedge clk);
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
        rst = 1'b0;
        push_exp(mk(0, 0, 0, 0, 0, 0));
        @(negedge clk);
        e = exp_q.pop_front();
        n_chk++;
        if (obs_vec() !== e) $display("FAIL reset_outputs: got %b want %b", obs_vec(), e);
        else n_pass++;
        n_chk++;
        if (stall_cnt !== '0 || flush_cnt !== '0)
            $display("FAIL reset_counters: got %0d/%0d want 0/0", stall_cnt, flush_cnt);
        else n_pass++;
    endtask

    task automatic test_forwarding();
        logic [4:0] t_rs1 [6] = '{5, 5, 3, 9, 9, 9};
        logic [4:0] t_rs2 [6] = '{5, 5, 7, 9, 4, 9};
        logic [4:0] t_rd  [6] = '{5, 0, 7, 9, 9, 9};
        logic       t_en  [6] = '{1, 1, 1, 1, 1, 0};
        logic [1:0] t_wb  [6] = '{2'b00, 2'b00, 2'b01, 2'b10, 2'b11, 2'b10};
        logic [1:0] t_fa  [6] = '{2'b01, 2'b00, 2'b00, 2'b11, 2'b01, 2'b00};
        logic [1:0] t_fb  [6] = '{2'b01, 2'b00, 2'b10, 2'b11, 2'b00, 2'b00};
        logic [9:0] e;
        for (int i = 0; i < 6; i++) begin
            drive(t_rs1[i], t_rs2[i], t_rd[i], t_en[i], t_wb[i], 0, 0, 0, 0);
            push_exp(mk(t_fa[i], t_fb[i], 0, 0, 0, 0));
            @(negedge clk);
            e = exp_q.pop_front();
            n_chk++;
            if (obs_vec() !== e) $display("FAIL fwd case %0d: got %b want %b", i, obs_vec(), e);
            else n_pass++;
        end
    endtask

    // Load in MEM/WB (forwarding load data to rs1) waits three cycles
    task automatic test_mem_wait();
        logic       rdy [5] = '{0, 0, 0, 1, 0};
        logic       acc [5] = '{1, 1, 1, 1, 0};
        logic       st  [5] = '{1, 1, 1, 0, 0};
        logic [9:0] e;
        int         cs, cf;
        for (int i = 0; i < 5; i++) begin
            drive(5, 2, 5, 1, 2'b01, acc[i], 0, rdy[i], 0);
            push_exp(mk(2'b10, 2'b00, st[i], 0, 0, 0));
            @(negedge clk);
            e = exp_q.pop_front();
            n_chk++;
            if (obs_vec() !== e) $display("FAIL mem_wait cycle %0d: got %b want %b", i, obs_vec(), e);
            else n_pass++;
        end
`ifdef HAZARD_PERF_CNT_EN
        cs = exp_stall; cf = exp_flush;
`else
        cs = 0; cf = 0;
`endif
        n_chk++;
        if (stall_cnt !== CNT_W'(cs) || flush_cnt !== CNT_W'(cf))
            $display("FAIL mem_wait_counters: got %0d/%0d want %0d/%0d", stall_cnt, flush_cnt, cs, cf);
        else n_pass++;
    endtask

    // Store never completes: MEM_TIMEOUT+1 stalled cycles, then one abort cycle
    task automatic test_timeout(input logic br);
        logic [9:0] e;
        int         cs, cf;
        for (int i = 0; i < MEM_TIMEOUT + 3; i++) begin
            if (i <= MEM_TIMEOUT + 1) drive(0, 0, 0, 0, 0, 0, 1, 0, br);
            else                      drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
            if (i <= MEM_TIMEOUT)          push_exp(mk(0, 0, 1, 0, 0, 0));
            else if (i == MEM_TIMEOUT + 1) push_exp(mk(0, 0, 0, br, 1, 1));
            else                           push_exp(mk(0, 0, 0, 0, 0, 0));
            @(negedge clk);
            e = exp_q.pop_front();
            n_chk++;
            if (obs_vec() !== e)
                $display("FAIL timeout(br=%0b) cycle %0d: got %b want %b", br, i, obs_vec(), e);
            else n_pass++;
        end
`ifdef HAZARD_PERF_CNT_EN
        cs = exp_stall; cf = exp_flush;
`else
        cs = 0; cf = 0;
`endif
        n_chk++;
        if (stall_cnt !== CNT_W'(cs) || flush_cnt !== CNT_W'(cf))
            $display("FAIL timeout_counters: got %0d/%0d want %0d/%0d", stall_cnt, flush_cnt, cs, cf);
        else n_pass++;
    endtask

    // Branch alone flushes at once; a branch held across a 2-cycle wait flushes on release
    task automatic test_branch();
        logic       acc [6] = '{0, 0, 1, 1, 1, 0};
        logic       rdy [6] = '{0, 0, 0, 0, 1, 0};
        logic       br  [6] = '{1, 0, 1, 1, 1, 0};
        logic       st  [6] = '{0, 0, 1, 1, 0, 0};
        logic       fl  [6] = '{1, 0, 0, 0, 1, 0};
        logic [9:0] e;
        for (int i = 0; i < 6; i++) begin
            drive(0, 0, 0, 0, 0, acc[i], 0, rdy[i], br[i]);
            push_exp(mk(0, 0, st[i], fl[i], 0, 0));
            @(negedge clk);
            e = exp_q.pop_front();
            n_chk++;
            if (obs_vec() !== e) $display("FAIL branch cycle %0d: got %b want %b", i, obs_vec(), e);
            else n_pass++;
        end
    endtask

    // Reset in the fifth stalled cycle drops the access without an error pulse
    task automatic test_reset_mid_wait();
        logic [9:0] e;
        for (int i = 0; i < 8; i++) begin
            if (i < 4) begin
                drive(0, 0, 0, 0, 0, 1, 0, 0, 0);
                push_exp(mk(0, 0, 1, 0, 0, 0));
            end else if (i == 4) begin
                @(posedge clk);
                #1;
                rst = 1'b1;
                exp_stall = 0;
                exp_flush = 0;
                push_exp(mk(0, 0, 0, 0, 0, 0));
            end else begin
                drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
                rst = 1'b0;
                push_exp(mk(0, 0, 0, 0, 0, 0));
            end
            @(negedge clk);
            e = exp_q.pop_front();
            n_chk++;
            if (obs_vec() !== e) $display("FAIL reset_mid_wait cycle %0d: got %b want %b", i, obs_vec(), e);
            else n_pass++;
            if (i == 4) begin
                n_chk++;
                if (stall_cnt !== '0 || flush_cnt !== '0)
                    $display("FAIL reset_mid_wait_counters: got %0d/%0d want 0/0", stall_cnt, flush_cnt);
                else n_pass++;
            end
        end
    endtask

    initial begin
        test_reset();
        test_forwarding();
        test_mem_wait();
        test_timeout(1'b0);
        test_branch();
        test_timeout(1'b1);
        test_reset_mid_wait();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
